// File: rtl/mips_boot_loader_pkg.sv
// Shared types and constants for the MIPS instruction-memory boot loader.
package mips_boot_loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = 2;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_GET_COUNT = 3'd1,
        ST_GET_BYTES = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RELEASE   = 3'd4,
        ST_DONE      = 3'd5
    } boot_state_e;

endpackage

// File: rtl/mips_boot_loader_word_assembler.sv
// Collects stream bytes MSB-first into a word; flags the byte that completes it.
module mips_boot_loader_word_assembler
    import mips_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid_c,
    output logic [DATA_W-1:0] word_c
);

    localparam int unsigned SHIFT_W = DATA_W - BYTE_W;

    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q,   cnt_d;

    // The completed word is the three held bytes plus the byte on the bus now.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        word_valid_c = byte_valid && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
        word_c       = {shift_q, byte_data};
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[SHIFT_W-BYTE_W-1:0], byte_data};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: parses framed byte stream, writes words to the MIPS init port,
// then releases the core from reset.
module mips_boot_loader
    import mips_boot_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 8,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [BYTE_W-1:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned       TIMEOUT_CYCLES = 1000,
    parameter int unsigned       RELEASE_DELAY  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    output logic              rx_ready,
    output logic              init,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned REL_W  = $clog2(RELEASE_DELAY + 1);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] words_left_q, words_left_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic              rx_ready_q, rx_ready_d;
    logic              init_q, init_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [DATA_W-1:0] init_data_q, init_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;

    logic              accept_c;
    logic              sync_c;
    logic              timeout_c;
    logic              asm_clear_c;
    logic              asm_byte_c;
    logic              word_valid_c;
    logic [DATA_W-1:0] word_c;

    mips_boot_loader_word_assembler #(
        .DATA_W (DATA_W)
    ) u_word_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (asm_clear_c),
        .byte_valid   (asm_byte_c),
        .byte_data    (rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        idle_d       = '0;
        rel_d        = '0;
        init_d       = 1'b0;
        init_addr_d  = init_addr_q;
        init_data_d  = init_data_q;
        load_error_d = load_error_q;
        asm_clear_c  = 1'b0;

        accept_c   = rx_valid && rx_ready_q;
        sync_c     = accept_c && (rx_data == SYNC_BYTE);
        asm_byte_c = accept_c && (state_q == ST_GET_BYTES);
        timeout_c  = !accept_c && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            ST_WAIT_SYNC, ST_DONE: begin
                if (sync_c) begin
                    state_d      = ST_GET_COUNT;
                    load_error_d = 1'b0;
                    addr_d       = '0;
                    asm_clear_c  = 1'b1;
                end
            end
            ST_GET_COUNT: begin
                if (accept_c) begin
                    words_left_d = rx_data;
                    state_d      = (rx_data == '0) ? ST_RELEASE : ST_GET_BYTES;
                end else if (timeout_c) begin
                    state_d      = ST_WAIT_SYNC;
                    load_error_d = 1'b1;
                    asm_clear_c  = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_GET_BYTES: begin
                if (accept_c) begin
                    if (word_valid_c) begin
                        state_d     = ST_WRITE;
                        init_d      = 1'b1;
                        init_addr_d = addr_q;
                        init_data_d = word_c;
                    end
                end else if (timeout_c) begin
                    state_d      = ST_WAIT_SYNC;
                    load_error_d = 1'b1;
                    asm_clear_c  = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            ST_WRITE: begin
                addr_d       = addr_q + 1'b1;
                words_left_d = words_left_q - 1'b1;
                state_d      = (words_left_q == BYTE_W'(1)) ? ST_RELEASE : ST_GET_BYTES;
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(RELEASE_DELAY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    rel_d = rel_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_SYNC;
            end
        endcase

        // Flag outputs follow the state being entered so they line up with it.
        rx_ready_d  = (state_d != ST_WRITE) && (state_d != ST_RELEASE);
        cpu_reset_d = (state_d != ST_DONE);
        load_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_WAIT_SYNC;
            addr_q       <= '0;
            words_left_q <= '0;
            idle_q       <= '0;
            rel_q        <= '0;
            rx_ready_q   <= 1'b1;
            init_q       <= 1'b0;
            init_addr_q  <= '0;
            init_data_q  <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            idle_q       <= idle_d;
            rel_q        <= rel_d;
            rx_ready_q   <= rx_ready_d;
            init_q       <= init_d;
            init_addr_q  <= init_addr_d;
            init_data_q  <= init_data_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign init       = init_q;
    assign init_addr  = init_addr_q;
    assign init_data  = init_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized scoreboard bench for mips_boot_loader: a frame-level model predicts
// init writes; a monitor pops and compares each observed init pulse.
module tb_mips_boot_loader;

    localparam int unsigned RELEASE_DELAY  = 4;
    localparam int unsigned TIMEOUT_CYCLES = 1000;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        init;
    logic [7:0]  init_addr;
    logic [31:0] init_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    mips_boot_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .init       (init),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  last_addr;
    logic [31:0] last_data;

    // Frame-level reference model: 0 = hunting sync, 1 = expect count,
    // 2 = collecting data, 3 = image loaded.
    int          m_phase;
    int          m_n;
    int          m_idx;
    int          m_nb;
    logic [31:0] m_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_nb    = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (m_phase)
            0, 3: if (b == 8'hA5) m_phase = 1;
            1: begin
                m_n     = int'(b);
                m_idx   = 0;
                m_nb    = 0;
                m_phase = (b == 8'h00) ? 3 : 2;
            end
            default: begin
                m_word = {m_word[23:0], b};
                m_nb++;
                if (m_nb == 4) begin
                    exp_q.push_back({8'(m_idx), m_word});
                    m_idx++;
                    m_nb = 0;
                    if (m_idx == m_n) m_phase = 3;
                end
            end
        endcase
    endtask

    // Monitor: every init pulse must match the oldest predicted write.
    always @(negedge clk) begin
        if (reset_n && init) begin
            last_addr = init_addr;
            last_data = init_data;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_init: addr %0h data %0h, no write expected", init_addr, init_data);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("init_addr", 64'(init_addr), 64'(e[39:32]));
                check("init_data", 64'(init_data), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        bit   ok;
        logic rdy;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rdy = rx_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (ok) model_byte(b);
        else check("byte_accept_timeout", 64'(0), 64'(1));
    endtask

    // Counts cycles the core is still held after the last write (or count byte).
    task automatic wait_release(input int skip);
        int k;
        k = 0;
        repeat (skip) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!cpu_reset) break;
            k++;
        end
        check("release_gap", 64'(k), 64'(RELEASE_DELAY));
        check("load_done", 64'(load_done), 64'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'(1));
        check({tag, "_init"}, 64'(init), 64'(0));
        check({tag, "_init_addr"}, 64'(init_addr), 64'(0));
        check({tag, "_init_data"}, 64'(init_data), 64'(0));
        check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
        check({tag, "_load_done"}, 64'(load_done), 64'(0));
        check({tag, "_load_error"}, 64'(load_error), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        #1;
        check_reset_vals("async_reset");
        repeat (2) begin
            @(negedge clk);
            check("reset_no_init", 64'(init), 64'(0));
        end
        rx_valid = 1'b0;
        reset_n  = 1'b1;
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t2[10];
        logic [7:0] b;
        int         nw;
        bit         aborted;

        t2 = '{8'hA5, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h01, 8'h00, 8'h08};
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rx_valid = 1'b0;
        reset_n  = 1'b1;

        // Idle after reset: nothing moves.
        repeat (5) @(negedge clk);
        check_reset_vals("idle");

        // Two-word image.
        foreach (t2[i]) send_byte(t2[i], 2);
        wait_release(1);
        check("t2_last_addr", 64'(last_addr), 64'(1));
        check("t2_last_data", 64'(last_data), 64'(32'hAC010008));

        // Junk then empty image, issued from DONE.
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        check("junk_in_done_cpu_reset", 64'(cpu_reset), 64'(0));
        send_byte(8'hA5, 1);
        send_byte(8'h00, 1);
        wait_release(0);

        // Timeout mid-word.
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        repeat (TIMEOUT_CYCLES - 10) @(negedge clk);
        check("pre_timeout_error", 64'(load_error), 64'(0));
        repeat (20) @(negedge clk);
        model_reset();
        check("timeout_error", 64'(load_error), 64'(1));
        check("timeout_rx_ready", 64'(rx_ready), 64'(1));
        check("timeout_cpu_reset", 64'(cpu_reset), 64'(1));
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("sync_clears_error", 64'(load_error), 64'(0));
        send_byte(8'h00, 0);
        wait_release(0);

        // Reload from DONE.
        send_byte(8'hA5, 0);
        @(negedge clk);
        check("reload_cpu_reset", 64'(cpu_reset), 64'(1));
        check("reload_load_done", 64'(load_done), 64'(0));
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_release(1);
        check("t5_last_addr", 64'(last_addr), 64'(0));
        check("t5_last_data", 64'(last_data), 64'(32'hDEADBEEF));

        // Random frames with gaps and one reset mid-word.
        for (int f = 0; f < 6; f++) begin
            aborted = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 3);
            end
            send_byte(8'hA5, 3);
            nw = $urandom_range(1, 5);
            send_byte(8'(nw), 3);
            for (int w = 0; w < nw && !aborted; w++) begin
                for (int k = 0; k < 4 && !aborted; k++) begin
                    if (f == 2 && w == nw - 1 && k == 2) begin
                        pulse_reset();
                        aborted = 1'b1;
                    end else begin
                        send_byte(8'($urandom), 3);
                    end
                end
            end
            if (!aborted) wait_release(1);
            else begin
                repeat (3) @(negedge clk);
                check_reset_vals("post_reset");
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
